// File: rtl/video_timing_pkg.sv
// Shared video timing definitions: FSM states, reference 640x480 timing
// constants (shared with the display timing generator) and the frame
// geometry record used by the timing analyzer.
package video_timing_pkg;

    // 640x480@60 reference timing (pixel clocks / lines)
    localparam int unsigned H_ACTIVE_640 = 640;
    localparam int unsigned H_FP_640     = 16;
    localparam int unsigned H_SYNC_640   = 96;
    localparam int unsigned H_TOTAL_640  = 800;
    localparam int unsigned V_ACTIVE_480 = 480;
    localparam int unsigned V_FP_480     = 10;
    localparam int unsigned V_SYNC_480   = 2;
    localparam int unsigned V_TOTAL_480  = 525;

    // Record fields are sized for the widest supported measurement counter
    localparam int unsigned REC_FIELD_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        CHECK   = 2'd2,
        LOCKED  = 2'd3
    } vta_state_e;

    typedef struct packed {
        logic [REC_FIELD_W-1:0] h_total;
        logic [REC_FIELD_W-1:0] h_active;
        logic [REC_FIELD_W-1:0] v_total;
        logic [REC_FIELD_W-1:0] v_active;
    } frame_rec_t;

endpackage

// File: rtl/vta_edge_detect.sv
// Stage-1 input registers for DE/HS/VS with sync polarity normalisation,
// plus single-cycle edge strobes derived from stage 1 vs. its previous value.
// Ports:
//   i_clk, i_rstn          clock, async active-low reset
//   i_de, i_hs, i_vs       raw video timing inputs
//   o_de                   stage-1 DE level
//   o_de_rise_c/o_de_fall_c DE edge strobes (combinational from flops)
//   o_hs_rise_c            asserted-edge of normalised HS
//   o_vs_rise_c            asserted-edge of normalised VS
module vta_edge_detect #(
    parameter bit SYNC_ACTIVE_HIGH = 1'b1
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_de,
    input  logic i_hs,
    input  logic i_vs,
    output logic o_de,
    output logic o_de_rise_c,
    output logic o_de_fall_c,
    output logic o_hs_rise_c,
    output logic o_vs_rise_c
);

    // {de, hs, vs}
    logic [2:0] s1_d, s1_q;
    logic [2:0] prev_d, prev_q;

    always_comb begin
        s1_d   = {i_de,
                  SYNC_ACTIVE_HIGH ? i_hs : ~i_hs,
                  SYNC_ACTIVE_HIGH ? i_vs : ~i_vs};
        prev_d = s1_q;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            s1_q   <= '0;
            prev_q <= '0;
        end else begin
            s1_q   <= s1_d;
            prev_q <= prev_d;
        end
    end

    assign o_de        = s1_q[2];
    assign o_de_rise_c = s1_q[2] & ~prev_q[2];
    assign o_de_fall_c = ~s1_q[2] & prev_q[2];
    assign o_hs_rise_c = s1_q[1] & ~prev_q[1];
    assign o_vs_rise_c = s1_q[0] & ~prev_q[0];

endmodule

// File: rtl/video_timing_analyzer.sv
// Receive-side video timing analyzer: recovers pixel coordinates from
// DE/HS/VS, measures line/frame geometry and declares lock once the geometry
// repeats for LOCK_FRAMES consecutive frames.
// Ports:
//   i_clk, i_rstn                  pixel clock, async active-low reset
//   i_de, i_hs, i_vs               incoming timing
//   o_de, o_x, o_y                 DE delayed 2 cycles with aligned coordinates
//   o_line_start, o_frame_start    pulses with first o_de of line / frame
//   o_h_total, o_h_active          clocks per line, DE clocks per line
//   o_v_total, o_v_active          lines per frame, DE lines per frame
//   o_locked                       geometry stable
module video_timing_analyzer
    import video_timing_pkg::*;
#(
    parameter bit          SYNC_ACTIVE_HIGH = 1'b1,
    parameter int unsigned COORD_W          = 10,
    parameter int unsigned MEAS_W           = 12,
    parameter int unsigned LOCK_FRAMES      = 2
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_de,
    input  logic               i_hs,
    input  logic               i_vs,
    output logic               o_de,
    output logic [COORD_W-1:0] o_x,
    output logic [COORD_W-1:0] o_y,
    output logic               o_line_start,
    output logic               o_frame_start,
    output logic [MEAS_W-1:0]  o_h_total,
    output logic [MEAS_W-1:0]  o_h_active,
    output logic [MEAS_W-1:0]  o_v_total,
    output logic [MEAS_W-1:0]  o_v_active,
    output logic               o_locked
);

    localparam int unsigned    MATCH_W  = 4;
    localparam logic [MEAS_W-1:0] MEAS_MAX = '1;

    logic de_s1, de_rise_c, de_fall_c, hs_rise_c, vs_rise_c;

    vta_edge_detect #(.SYNC_ACTIVE_HIGH(SYNC_ACTIVE_HIGH)) u_edge (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_de        (i_de),
        .i_hs        (i_hs),
        .i_vs        (i_vs),
        .o_de        (de_s1),
        .o_de_rise_c (de_rise_c),
        .o_de_fall_c (de_fall_c),
        .o_hs_rise_c (hs_rise_c),
        .o_vs_rise_c (vs_rise_c)
    );

    function automatic logic [MEAS_W-1:0] sat_inc(input logic [MEAS_W-1:0] v);
        return (v == MEAS_MAX) ? v : v + MEAS_W'(1);
    endfunction

    // Stage 2 / coordinate state
    logic               o_de_d, o_de_q, o_ls_d, o_ls_q, o_fs_d, o_fs_q;
    logic [COORD_W-1:0] o_x_d, o_x_q, o_y_d, o_y_q;
    logic [COORD_W-1:0] pix_x_d, pix_x_q, line_y_d, line_y_q;
    logic               y_valid_d, y_valid_q, vs_seen_d, vs_seen_q;
    logic [COORD_W-1:0] x_now, y_now;
    logic               y_first;

    // Measurement state
    logic [MEAS_W-1:0]  h_cnt_d, h_cnt_q, de_cnt_d, de_cnt_q;
    logic [MEAS_W-1:0]  hs_lines_d, hs_lines_q, de_lines_d, de_lines_q;
    logic [MEAS_W-1:0]  h_ref_d, h_ref_q, de_ref_d, de_ref_q;
    logic               h_ref_vld_d, h_ref_vld_q, de_ref_vld_d, de_ref_vld_q;
    logic               bad_d, bad_q;
    logic [MEAS_W-1:0]  hs_lines_inc, de_lines_inc, h_ref_now, de_ref_now;
    logic               line_mis, cnt_sat, bad_now;
    frame_rec_t         rec;

    // Lock FSM and measurement outputs
    vta_state_e         state_d, state_q;
    logic [MATCH_W-1:0] match_d, match_q, match_inc;
    frame_rec_t         stored_d, stored_q;
    logic               rec_ok, watchdog;
    logic               o_locked_d, o_locked_q;
    logic [MEAS_W-1:0]  o_ht_d, o_ht_q, o_ha_d, o_ha_q, o_vt_d, o_vt_q, o_va_d, o_va_q;

    // Coordinate recovery; a VS rise coinciding with a DE rise starts y at 0
    always_comb begin
        y_first   = !y_valid_q || vs_rise_c;
        x_now     = de_rise_c ? '0 : COORD_W'(pix_x_q + COORD_W'(1));
        y_now     = line_y_q;
        if (de_rise_c) y_now = y_first ? '0 : COORD_W'(line_y_q + COORD_W'(1));
        pix_x_d   = de_s1 ? x_now : pix_x_q;
        line_y_d  = y_now;
        y_valid_d = y_valid_q;
        if (vs_rise_c) y_valid_d = 1'b0;
        if (de_rise_c) y_valid_d = 1'b1;
        vs_seen_d = vs_seen_q | vs_rise_c;
        o_de_d    = de_s1;
        o_x_d     = de_s1 ? x_now : '0;
        o_y_d     = de_s1 ? y_now : '0;
        o_ls_d    = de_rise_c;
        o_fs_d    = de_rise_c && y_first && (vs_seen_q || vs_rise_c);
    end

    // Line/frame measurement; events on the VS-rise cycle belong to the ending frame
    always_comb begin
        h_cnt_d      = hs_rise_c ? MEAS_W'(1) : sat_inc(h_cnt_q);
        de_cnt_d     = de_cnt_q;
        if (de_s1) de_cnt_d = de_rise_c ? MEAS_W'(1) : sat_inc(de_cnt_q);
        hs_lines_inc = hs_rise_c ? sat_inc(hs_lines_q) : hs_lines_q;
        de_lines_inc = de_rise_c ? sat_inc(de_lines_q) : de_lines_q;
        h_ref_now    = (hs_rise_c && !h_ref_vld_q) ? h_cnt_q : h_ref_q;
        de_ref_now   = (de_fall_c && !de_ref_vld_q) ? de_cnt_q : de_ref_q;
        line_mis     = (hs_rise_c && h_ref_vld_q && (h_cnt_q != h_ref_q)) ||
                       (de_fall_c && de_ref_vld_q && (de_cnt_q != de_ref_q));
        cnt_sat      = (h_cnt_q == MEAS_MAX) || (de_cnt_q == MEAS_MAX) ||
                       (hs_lines_q == MEAS_MAX) || (de_lines_q == MEAS_MAX);
        bad_now      = bad_q || line_mis || cnt_sat;

        rec.h_total  = REC_FIELD_W'(h_ref_now);
        rec.h_active = REC_FIELD_W'(de_ref_now);
        rec.v_total  = REC_FIELD_W'(hs_lines_inc);
        rec.v_active = REC_FIELD_W'(de_lines_inc);

        hs_lines_d   = hs_lines_inc;
        de_lines_d   = de_lines_inc;
        h_ref_d      = h_ref_now;
        de_ref_d     = de_ref_now;
        h_ref_vld_d  = h_ref_vld_q | hs_rise_c;
        de_ref_vld_d = de_ref_vld_q | de_fall_c;
        bad_d        = bad_now;
        if (vs_rise_c) begin
            hs_lines_d   = '0;
            de_lines_d   = '0;
            h_ref_d      = '0;
            de_ref_d     = '0;
            h_ref_vld_d  = 1'b0;
            de_ref_vld_d = 1'b0;
            bad_d        = 1'b0;
        end
    end

    // Lock FSM, advanced once per VS rise; HS loss forces IDLE
    always_comb begin
        state_d   = state_q;
        match_d   = match_q;
        stored_d  = stored_q;
        match_inc = match_q + MATCH_W'(1);
        watchdog  = (h_cnt_q == MEAS_MAX) && !hs_rise_c;
        rec_ok    = !bad_now && (rec == stored_q) &&
                    (rec.h_total != '0) && (rec.h_active != '0) &&
                    (rec.v_total != '0) && (rec.v_active != '0);
        o_ht_d    = o_ht_q;
        o_ha_d    = o_ha_q;
        o_vt_d    = o_vt_q;
        o_va_d    = o_va_q;

        if (watchdog) begin
            state_d = IDLE;
            match_d = '0;
        end else if (vs_rise_c) begin
            if (state_q != IDLE && !bad_now) begin
                o_ht_d = h_ref_now;
                o_ha_d = de_ref_now;
                o_vt_d = hs_lines_inc;
                o_va_d = de_lines_inc;
            end
            case (state_q)
                IDLE: state_d = MEASURE;
                MEASURE: begin
                    stored_d = rec;
                    match_d  = '0;
                    state_d  = CHECK;
                end
                CHECK: begin
                    if (rec_ok) begin
                        match_d = match_inc;
                        if (match_inc >= MATCH_W'(LOCK_FRAMES)) state_d = LOCKED;
                    end else begin
                        stored_d = rec;
                        match_d  = '0;
                    end
                end
                LOCKED: begin
                    if (!rec_ok) begin
                        stored_d = rec;
                        match_d  = '0;
                        state_d  = CHECK;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        o_locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_de_q       <= 1'b0;
            o_x_q        <= '0;
            o_y_q        <= '0;
            o_ls_q       <= 1'b0;
            o_fs_q       <= 1'b0;
            pix_x_q      <= '0;
            line_y_q     <= '0;
            y_valid_q    <= 1'b0;
            vs_seen_q    <= 1'b0;
            h_cnt_q      <= '0;
            de_cnt_q     <= '0;
            hs_lines_q   <= '0;
            de_lines_q   <= '0;
            h_ref_q      <= '0;
            de_ref_q     <= '0;
            h_ref_vld_q  <= 1'b0;
            de_ref_vld_q <= 1'b0;
            bad_q        <= 1'b0;
            state_q      <= IDLE;
            match_q      <= '0;
            stored_q     <= '0;
            o_locked_q   <= 1'b0;
            o_ht_q       <= '0;
            o_ha_q       <= '0;
            o_vt_q       <= '0;
            o_va_q       <= '0;
        end else begin
            o_de_q       <= o_de_d;
            o_x_q        <= o_x_d;
            o_y_q        <= o_y_d;
            o_ls_q       <= o_ls_d;
            o_fs_q       <= o_fs_d;
            pix_x_q      <= pix_x_d;
            line_y_q     <= line_y_d;
            y_valid_q    <= y_valid_d;
            vs_seen_q    <= vs_seen_d;
            h_cnt_q      <= h_cnt_d;
            de_cnt_q     <= de_cnt_d;
            hs_lines_q   <= hs_lines_d;
            de_lines_q   <= de_lines_d;
            h_ref_q      <= h_ref_d;
            de_ref_q     <= de_ref_d;
            h_ref_vld_q  <= h_ref_vld_d;
            de_ref_vld_q <= de_ref_vld_d;
            bad_q        <= bad_d;
            state_q      <= state_d;
            match_q      <= match_d;
            stored_q     <= stored_d;
            o_locked_q   <= o_locked_d;
            o_ht_q       <= o_ht_d;
            o_ha_q       <= o_ha_d;
            o_vt_q       <= o_vt_d;
            o_va_q       <= o_va_d;
        end
    end

    assign o_de          = o_de_q;
    assign o_x           = o_x_q;
    assign o_y           = o_y_q;
    assign o_line_start  = o_ls_q;
    assign o_frame_start = o_fs_q;
    assign o_h_total     = o_ht_q;
    assign o_h_active    = o_ha_q;
    assign o_v_total     = o_vt_q;
    assign o_v_active    = o_va_q;
    assign o_locked      = o_locked_q;

endmodule

// File: tb/tb_video_timing_analyzer.sv
// Bench for video_timing_analyzer using a compact 8x4-active timing
// (16 clocks/line, 8 lines/frame). Two instances run side by side: one with
// active-high syncs and one with inverted syncs, both held to the same
// expectations. Pixel outputs are checked through a scoreboard queue filled
// as stimulus is driven; lock and measurements are checked at directed points.
module tb_video_timing_analyzer;

    logic i_clk, i_rstn, i_de, i_hs, i_vs;
    logic hs_n, vs_n;

    logic       p_de, p_ls, p_fs, p_lock;
    logic [9:0] p_x, p_y;
    logic [11:0] p_ht, p_ha, p_vt, p_va;
    logic       n_de, n_ls, n_fs, n_lock;
    logic [9:0] n_x, n_y;
    logic [11:0] n_ht, n_ha, n_vt, n_va;

    assign hs_n = ~i_hs;
    assign vs_n = ~i_vs;

    video_timing_analyzer u_dut_p (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_de(i_de), .i_hs(i_hs), .i_vs(i_vs),
        .o_de(p_de), .o_x(p_x), .o_y(p_y), .o_line_start(p_ls), .o_frame_start(p_fs),
        .o_h_total(p_ht), .o_h_active(p_ha), .o_v_total(p_vt), .o_v_active(p_va),
        .o_locked(p_lock)
    );

    video_timing_analyzer #(.SYNC_ACTIVE_HIGH(1'b0)) u_dut_n (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_de(i_de), .i_hs(hs_n), .i_vs(vs_n),
        .o_de(n_de), .o_x(n_x), .o_y(n_y), .o_line_start(n_ls), .o_frame_start(n_fs),
        .o_h_total(n_ht), .o_h_active(n_ha), .o_v_total(n_vt), .o_v_active(n_va),
        .o_locked(n_lock)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        int          due;
        logic [22:0] exp;
    } sb_t;

    sb_t sb[$];
    int  cyc = 0;
    int  n_checks = 0;
    int  n_errors = 0;

    // Reference pixel model state
    logic m_pde = 1'b0, m_pvs = 1'b0;
    bit   m_yfirst = 1'b1, m_vs_seen = 1'b0;
    int   m_x = 0, m_y = 0;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One pixel clock: score due outputs, then drive (or hold reset)
    task automatic drive_cycle(input logic de, input logic hs, input logic vs, input bit rst);
        sb_t  e;
        logic ls, fs;
        @(negedge i_clk);
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check("pix_p", 72'({p_de, p_x, p_y, p_ls, p_fs}), 72'(e.exp));
            check("pix_n", 72'({n_de, n_x, n_y, n_ls, n_fs}), 72'(e.exp));
        end
        i_de = de;
        i_hs = hs;
        i_vs = vs;
        if (rst) begin
            i_rstn = 1'b0;
            #1;
            check("rst_p", {p_de, p_x, p_y, p_ls, p_fs, p_ht, p_ha, p_vt, p_va, p_lock}, 72'd0);
            check("rst_n", {n_de, n_x, n_y, n_ls, n_fs, n_ht, n_ha, n_vt, n_va, n_lock}, 72'd0);
            sb.delete();
            m_pde = 1'b0; m_pvs = 1'b0; m_yfirst = 1'b1; m_vs_seen = 1'b0;
            m_x = 0; m_y = 0;
        end else begin
            i_rstn = 1'b1;
            ls = 1'b0;
            fs = 1'b0;
            if (vs && !m_pvs) begin
                m_vs_seen = 1'b1;
                m_yfirst  = 1'b1;
            end
            if (de && !m_pde) begin
                ls       = 1'b1;
                fs       = m_yfirst && m_vs_seen;
                m_y      = m_yfirst ? 0 : m_y + 1;
                m_yfirst = 1'b0;
                m_x      = 0;
            end else if (de) begin
                m_x++;
            end
            e.due = cyc + 2;
            e.exp = {de, de ? 10'(m_x) : 10'd0, de ? 10'(m_y) : 10'd0, ls, fs};
            sb.push_back(e);
            m_pde = de;
            m_pvs = vs;
        end
        cyc++;
    endtask

    task automatic check_lock(input string tag, input logic exp);
        check({tag, "_p"}, 72'(p_lock), 72'(exp));
        check({tag, "_n"}, 72'(n_lock), 72'(exp));
    endtask

    task automatic check_meas(input string tag, input bit exp_meas);
        logic [47:0] exp;
        exp = exp_meas ? {12'd16, 12'd8, 12'd8, 12'd4} : 48'd0;
        check({tag, "_p"}, 72'({p_ht, p_ha, p_vt, p_va}), 72'(exp));
        check({tag, "_n"}, 72'({n_ht, n_ha, n_vt, n_va}), 72'(exp));
    endtask

    // One frame: HS at clocks 0-1, VS on lines 0-1, DE on lines 2-5 clocks 4-11.
    // Lock is checked before (clock 1) and after (clock 2) the frame's VS rise.
    task automatic run_frame(input bit long_line, input int rst_at,
                             input logic exp_old, input logic exp_new, input bit exp_meas);
        int idx = 0;
        int len;
        for (int l = 0; l < 8; l++) begin
            len = (long_line && l == 4) ? 17 : 16;
            for (int c = 0; c < len; c++) begin
                drive_cycle((l >= 2 && l < 6 && c >= 4 && c < 12), (c < 2), (l < 2), (idx == rst_at));
                if (l == 0 && c == 1) check_lock("lock_pre", exp_old);
                if (l == 0 && c == 2) begin
                    check_lock("lock_post", exp_new);
                    check_meas("meas", exp_meas);
                end
                idx++;
            end
        end
    endtask

    initial begin
        i_rstn = 1'b0;
        i_de   = 1'b0;
        i_hs   = 1'b0;
        i_vs   = 1'b0;

        repeat (2) drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);

        // Acquire lock: 4th VS rise locks
        run_frame(1'b0, -1, 1'b0, 1'b0, 1'b0);
        run_frame(1'b0, -1, 1'b0, 1'b0, 1'b1);
        run_frame(1'b0, -1, 1'b0, 1'b0, 1'b1);
        run_frame(1'b0, -1, 1'b0, 1'b1, 1'b1);
        run_frame(1'b0, -1, 1'b1, 1'b1, 1'b1);
        // 17-clock line in 6th frame: unlock after 7th VS rise, relock at 9th
        run_frame(1'b1, -1, 1'b1, 1'b1, 1'b1);
        run_frame(1'b0, -1, 1'b1, 1'b0, 1'b1);
        run_frame(1'b0, -1, 1'b0, 1'b0, 1'b1);
        run_frame(1'b0, -1, 1'b0, 1'b1, 1'b1);
        run_frame(1'b0, -1, 1'b1, 1'b1, 1'b1);

        // HS loss: still locked shortly before the watchdog limit, unlocked after
        repeat (4000) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check_lock("wd_early", 1'b1);
        repeat (200) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check_lock("wd_fired", 1'b0);
        check_meas("wd_meas", 1'b1);

        // After the watchdog the FSM restarts from IDLE: four VS rises to lock
        run_frame(1'b0, -1, 1'b0, 1'b0, 1'b1);
        run_frame(1'b0, -1, 1'b0, 1'b0, 1'b1);
        run_frame(1'b0, -1, 1'b0, 1'b0, 1'b1);
        run_frame(1'b0, -1, 1'b0, 1'b1, 1'b1);

        // Reset mid-line while locked (DE high), then relock after 4 VS rises
        run_frame(1'b0, 54, 1'b1, 1'b1, 1'b1);
        run_frame(1'b0, -1, 1'b0, 1'b0, 1'b0);
        run_frame(1'b0, -1, 1'b0, 1'b0, 1'b1);
        run_frame(1'b0, -1, 1'b0, 1'b0, 1'b1);
        run_frame(1'b0, -1, 1'b0, 1'b1, 1'b1);

        // Flush the pixels still in flight
        repeat (3) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
